// File: rtl/multi_button_debouncer.sv
// Multi-channel push-button / switch debouncer.
// Each channel: 2-flop synchronizer, stable-time counter, debounced level,
// registered press/release ticks and an optional auto-repeat tick generator.
module multi_button_debouncer #(
  parameter int NCH           = 4,
  parameter int STABLE_CYCLES = 500000,
  parameter bit ACTIVE_LOW    = 1'b0,
  parameter bit REPEAT_EN     = 1'b0,
  parameter int REPEAT_DELAY  = 25000000,
  parameter int REPEAT_PERIOD = 5000000
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [NCH-1:0] sw,
  output logic [NCH-1:0] db_level,
  output logic [NCH-1:0] rise_tick,
  output logic [NCH-1:0] fall_tick,
  output logic [NCH-1:0] rep_tick
);

  localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DELAY  = 2'd1,
    ST_REPEAT = 2'd2
  } rep_state_t;

  logic [NCH-1:0] sync_p0;
  logic [NCH-1:0] sync_p1;
  logic [NCH-1:0] s_in;

  // Synchronizer; flops idle at the inactive pin level so reset never looks like a press
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_p0 <= {NCH{ACTIVE_LOW}};
      sync_p1 <= {NCH{ACTIVE_LOW}};
    end else begin
      sync_p0 <= sw;
      sync_p1 <= sync_p0;
    end
  end

  // After synchronization, normalise polarity so 1 always means pressed
  assign s_in = sync_p1 ^ {NCH{ACTIVE_LOW}};

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    logic [CNT_W-1:0] cnt;
    logic             db_r;
    logic             rise_r;
    logic             fall_r;

    // Stable counter: flip the level only after STABLE_CYCLES consecutive disagreements
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        cnt    <= '0;
        db_r   <= 1'b0;
        rise_r <= 1'b0;
        fall_r <= 1'b0;
      end else begin
        rise_r <= 1'b0;
        fall_r <= 1'b0;
        if (s_in[i] == db_r) begin
          cnt <= '0;
        end else if (cnt == CNT_LAST) begin
          cnt    <= '0;
          db_r   <= ~db_r;
          rise_r <= ~db_r;
          fall_r <= db_r;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end

    assign db_level[i]  = db_r;
    assign rise_tick[i] = rise_r;
    assign fall_tick[i] = fall_r;

    if (REPEAT_EN) begin : g_rep
      localparam int RMAX   = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
      localparam int RCNT_W = $clog2(RMAX);
      localparam logic [RCNT_W-1:0] DELAY_LAST  = RCNT_W'(REPEAT_DELAY - 1);
      localparam logic [RCNT_W-1:0] PERIOD_LAST = RCNT_W'(REPEAT_PERIOD - 1);

      rep_state_t        state;
      rep_state_t        state_nxt;
      logic [RCNT_W-1:0] rcnt;
      logic [RCNT_W-1:0] rcnt_nxt;
      logic              rep;

      // Repeat FSM state and interval counter
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          state <= ST_IDLE;
          rcnt  <= '0;
        end else begin
          state <= state_nxt;
          rcnt  <= rcnt_nxt;
        end
      end

      // Next state: a released key always wins over a pending repeat
      always_comb begin
        state_nxt = state;
        rcnt_nxt  = rcnt;
        if (!db_r) begin
          state_nxt = ST_IDLE;
          rcnt_nxt  = '0;
        end else begin
          case (state)
            ST_IDLE: begin
              if (rise_r) begin
                state_nxt = ST_DELAY;
                rcnt_nxt  = '0;
              end
            end
            ST_DELAY: begin
              if (rcnt == DELAY_LAST) begin
                state_nxt = ST_REPEAT;
                rcnt_nxt  = '0;
              end else begin
                rcnt_nxt = rcnt + 1'b1;
              end
            end
            ST_REPEAT: begin
              if (rcnt == PERIOD_LAST) rcnt_nxt = '0;
              else                     rcnt_nxt = rcnt + 1'b1;
            end
            default: begin
              state_nxt = ST_IDLE;
              rcnt_nxt  = '0;
            end
          endcase
        end
      end

      // Repeat pulse decoded from registered state only
      always_comb begin
        rep = 1'b0;
        if (db_r) begin
          case (state)
            ST_IDLE:   rep = rise_r;
            ST_DELAY:  rep = (rcnt == DELAY_LAST);
            ST_REPEAT: rep = (rcnt == PERIOD_LAST);
            default:   rep = 1'b0;
          endcase
        end
      end

      assign rep_tick[i] = rep;
    end else begin : g_norep
      assign rep_tick[i] = rise_r;
    end
  end

endmodule

// File: doc/multi_button_debouncer.md
Name: multi_button_debouncer

Overview:
- NCH-channel counter-based debouncer for push-buttons and slide switches.
- Each channel has a 2-flop synchronizer, a stable-time counter, a debounced level, and press/release ticks.
- An optional auto-repeat tick generator supports held keys for menu and counter UIs.
- Sits between raw board pins and control FSMs; one instance replaces per-button shift-register debouncers.

Parameters:
- NCH, 4, number of independent channels (>=1).
- STABLE_CYCLES, 500000, consecutive cycles the synced input must disagree with db_level before db_level flips (>=1).
- ACTIVE_LOW, 0, 1 = raw pin is pressed-low; input is inverted after synchronization.
- REPEAT_EN, 0, 1 = enable the rep_tick generator; 0 = rep_tick equals rise_tick.
- REPEAT_DELAY, 25000000, held cycles after the press before the first repeat pulse (>=2).
- REPEAT_PERIOD, 5000000, cycles between subsequent repeat pulses (>=2).

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- sw  in  NCH  raw, asynchronous button inputs
- db_level  out  NCH  debounced level, 1 = pressed
- rise_tick  out  NCH  1-cycle pulse on press
- fall_tick  out  NCH  1-cycle pulse on release
- rep_tick  out  NCH  press pulse plus auto-repeat pulses

Behaviour:
- One clock (clk). Reset is asynchronous and active-high (reset); all state clears immediately on assertion.
- Reset values:
  - db_level, rise_tick, fall_tick and rep_tick are all 0.
  - All counters are 0.
  - Synchronizer flops reset to ACTIVE_LOW, so an idle pin produces no spurious press after reset.
- Per channel i, fully independent; no cross-channel interaction.
- Synchronization and polarity:
  - s1 <= sw[i]; s2 <= s1.
  - s_in = s2 XOR ACTIVE_LOW.
- Stable counter, width $clog2(STABLE_CYCLES+1):
  - If s_in == db_level: cnt <= 0.
  - Else if cnt == STABLE_CYCLES-1: db_level <= ~db_level and cnt <= 0.
  - Else: cnt <= cnt + 1.
- Any single-cycle return to agreement (a bounce) restarts the count from 0. Pulses shorter than STABLE_CYCLES never reach db_level.
- Latency: if sw settles before edge k (the first edge to sample it), db_level changes after edge k+1+STABLE_CYCLES. Total is STABLE_CYCLES+2 edges.
- Ticks:
  - rise_tick[i] is high exactly in the first cycle db_level[i] reads 1.
  - fall_tick[i] is high exactly in the first cycle db_level[i] reads 0.
  - Never both in the same cycle. Never asserted in the cycle after reset deasserts unless db_level actually changed.
- Repeat FSM (REPEAT_EN=1), states IDLE, DELAY, REPEAT:
  - IDLE: on rise_tick, assert rep_tick the same cycle, load rcnt=0, go to DELAY.
  - DELAY: rcnt increments each cycle. When rcnt == REPEAT_DELAY-1, pulse rep_tick, set rcnt=0, go to REPEAT. First repeat pulse is REPEAT_DELAY cycles after the press pulse.
  - REPEAT: when rcnt == REPEAT_PERIOD-1, pulse rep_tick and set rcnt=0. Pulses are spaced exactly REPEAT_PERIOD cycles apart.
  - In any state, db_level == 0 returns to IDLE and clears rcnt; no rep_tick in that cycle.
  - Release takes priority over a coinciding repeat-pulse condition.
- rcnt width is $clog2(max(REPEAT_DELAY, REPEAT_PERIOD)).
- When REPEAT_EN=0, rep_tick = rise_tick and the repeat logic is removed.
- All outputs are registered, or derived only from registered state with no path from sw. Glitch-free.
- Reset mid-count or mid-repeat aborts immediately. No tick is emitted on reset deassertion.

Test Plan:
- Use NCH=2, STABLE_CYCLES=8, ACTIVE_LOW=0, REPEAT_EN=1, REPEAT_DELAY=20, REPEAT_PERIOD=5 unless stated otherwise.
- Clean press: sw[0] 0->1 before edge 0 -> db_level[0]=1 after edge 9; rise_tick[0] high for 1 cycle; sw[1] path unaffected. Clean release -> fall_tick[0] single pulse, 10 edges after the change.
- Bounce rejection: toggle sw[0] with high runs of 7, 3 and 5 cycles separated by 1-cycle lows, then hold high -> no db_level change during bouncing; db_level=1 exactly 10 edges after the final settle; exactly one rise_tick.
- Auto-repeat: hold sw[0] high for 60 cycles past rise -> rep_tick at press+0, +20, +25, +30, ... +55, i.e. 9 pulses total. Release -> no further rep_tick; FSM returns to IDLE.
- Release during DELAY: press, release at rcnt=12 -> exactly 1 rep_tick; a later re-press restarts DELAY from 0, so its first repeat lands 20 cycles after the new rise.
- ACTIVE_LOW=1, sw held 1 through reset -> db_level=0, no ticks. Drive sw=0 -> rise_tick after 10 edges.
- Reset asserted mid-count (cnt=5) and mid-REPEAT -> all outputs 0 asynchronously. After deassertion with sw=1 held, a full 10-edge latency applies again, followed by a single rise_tick.
